// File: rtl/mul_div_unit_pkg.sv
// Shared CPU definitions: ALU opcodes, HI/LO unit op codes and FSM states.
// Imported by the EX stage and the multiply/divide unit.
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } aluOp_e;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } mdState_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage <-> multiply/divide unit bundle.
// master = EX stage, slave = HI/LO unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             start;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             mf_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, flush, mf_req,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush, mf_req,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mul_div_datapath.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide.
// Multiply keeps the multiplier in accLo; divide keeps the dividend there.
module mul_div_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] stepHi,
    output logic [WIDTH-1:0] stepLo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diffLo;
    logic             fits;

    always_comb begin
        sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
        shifted = {accHi, accLo[WIDTH-1]};
        fits    = shifted[WIDTH] || (shifted[WIDTH-1:0] >= opnd);
        // When the divisor fits, the true difference is below 2^WIDTH.
        diffLo  = shifted[WIDTH-1:0] - opnd;
        stepHi  = sum[WIDTH:1];
        stepLo  = {sum[0], accLo[WIDTH-1:1]};
        unique case (1'b1)
            isDiv && fits: begin
                stepHi = diffLo;
                stepLo = {accLo[WIDTH-2:0], 1'b1};
            end
            isDiv && !fits: begin
                stepHi = shifted[WIDTH-1:0];
                stepLo = {accLo[WIDTH-2:0], 1'b0};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies signs in FIXUP.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic           clock,
    input logic           reset,
    mul_div_unit_if.slave md
);
    localparam int CW = $clog2(WIDTH + 1);

    mdState_e         state;
    mdState_e         stateNext;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opnd;
    logic             isDiv;
    logic             negLo;
    logic             negHi;
    logic             divZero;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             busyReg;
    logic             doneReg;

    logic             isMdOp;
    logic             isDivOp;
    logic             signedOp;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fixHi;
    logic [WIDTH-1:0] fixLo;

    assign isMdOp   = md.op <= OPW'(MD_DIVU);
    assign isDivOp  = (md.op == OPW'(MD_DIV)) || (md.op == OPW'(MD_DIVU));
    assign signedOp = (md.op == OPW'(MD_MULT)) || (md.op == OPW'(MD_DIV));
    assign aNeg     = signedOp && md.operand_a[WIDTH-1];
    assign bNeg     = signedOp && md.operand_b[WIDTH-1];
    assign magA     = aNeg ? -md.operand_a : md.operand_a;
    assign magB     = bNeg ? -md.operand_b : md.operand_b;

    mul_div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .isDiv  (isDiv),
        .accHi  (accHi),
        .accLo  (accLo),
        .opnd   (opnd),
        .stepHi (stepHi),
        .stepLo (stepLo)
    );

    always_comb begin
        prod  = {accHi, accLo};
        fixHi = accHi;
        fixLo = accLo;
        if (!isDiv) begin
            if (negLo) prod = -prod;
            {fixHi, fixLo} = prod;
        end else begin
            fixLo = divZero ? '1 : (negLo ? -accLo : accLo);
            fixHi = negHi ? -accHi : accHi;
        end
    end

    always_comb begin
        stateNext = state;
        if (md.flush) begin
            stateNext = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (md.start && isMdOp) stateNext = ST_RUN;
                ST_RUN:   if (cnt == CW'(1)) stateNext = ST_FIXUP;
                ST_FIXUP: stateNext = ST_IDLE;
                default:  stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opnd    <= '0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            busyReg <= stateNext != ST_IDLE;
            doneReg <= 1'b0;
            if (!md.flush) begin
                unique case (state)
                    ST_IDLE: begin
                        if (md.start && isMdOp) begin
                            cnt     <= CW'(WIDTH);
                            accHi   <= '0;
                            accLo   <= magA;
                            opnd    <= magB;
                            isDiv   <= isDivOp;
                            negLo   <= aNeg ^ bNeg;
                            negHi   <= aNeg;
                            divZero <= md.operand_b == '0;
                        end else if (md.start && md.op == OPW'(MD_MTHI)) begin
                            hiReg <= md.operand_a;
                        end else if (md.start && md.op == OPW'(MD_MTLO)) begin
                            loReg <= md.operand_a;
                        end
                    end
                    ST_RUN: begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        cnt   <= cnt - CW'(1);
                    end
                    ST_FIXUP: begin
                        hiReg   <= fixHi;
                        loReg   <= fixLo;
                        doneReg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // MFHI/MFLO must wait for an operation in flight or being launched now.
    assign md.stall = !reset && md.mf_req && (busyReg || (md.start && isMdOp));
    assign md.busy  = busyReg;
    assign md.done  = doneReg;
    assign md.hi    = hiReg;
    assign md.lo    = loReg;

endmodule
